fifo_reader: RTL

Read-side controller for the FIFO, running on the read clock. It pops words whenever the FIFO reports not-empty and buffer space exists, and absorbs the FIFO's one-cycle read latency in a 3-entry skid buffer. Words are presented to the downstream consumer over a valid/ready handshake, and the stream is framed into fixed-length bursts with a last-beat marker.

---
 rtl/fifo_reader.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: read-side FIFO controller with a 3-entry skid buffer and fixed-length burst framing.
// Define FIFO_READER_STATS_EN to add the wordCount/burstCount statistics outputs.
module fifo_reader #(
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  parameter int CNT_W = 3
) (
  input  logic             clkB,
  input  logic             reset,
  input  logic             isEmpty,
  input  logic [WIDTH-1:0] fifoData,
  output logic             rdEn,
  output logic [WIDTH-1:0] data_out,
  output logic             isValid,
  input  logic             isReady,
  output logic             isLast
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]      wordCount,
  output logic [15:0]      burstCount
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } occ_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  logic [WIDTH-1:0] mem [3];
  logic [1:0]       rd_idx;
  logic [1:0]       wr_idx;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             in_flight;
  logic [CNT_W-1:0] beat_cnt;
  occ_e             occ;
  occ_e             occ_nxt;
  logic [2:0]       occupancy;
  logic             capture;
  logic             accept;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // The word popped last cycle is on fifoData now, so in-flight words count against buffer space.
  assign occupancy = {1'b0, count} + {2'b00, in_flight};
  assign rdEn      = !reset && !isEmpty && (occupancy < 3'd3);

  assign capture  = in_flight;
  assign accept   = isValid && isReady;
  assign isValid  = (occ != S_EMPTY);
  assign data_out = isValid ? mem[rd_idx] : '0;
  assign isLast   = isValid && (beat_cnt == LAST_BEAT);

  // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    count_nxt = count;
    occ_nxt   = occ;
    case ({capture, accept})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
    case (count_nxt)
      2'd0:    occ_nxt = S_EMPTY;
      2'd3:    occ_nxt = S_FULL;
      default: occ_nxt = S_PARTIAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkB) begin
    if (reset) begin
      rd_idx    <= 2'd0;
      wr_idx    <= 2'd0;
      count     <= 2'd0;
      in_flight <= 1'b0;
      beat_cnt  <= '0;
      occ       <= S_EMPTY;
    end else begin
      in_flight <= rdEn;
      count     <= count_nxt;
      occ       <= occ_nxt;
      if (capture) wr_idx <= next_idx(wr_idx);
      if (accept) begin
        rd_idx   <= next_idx(rd_idx);
        beat_cnt <= isLast ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  // NOTE: buffer storage has no reset; isValid gates it, so stale contents are never observed.
  always_ff @(posedge clkB) begin
    if (capture && !reset) mem[wr_idx] <= fifoData;
  end

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clkB) begin
    if (reset) begin
      wordCount  <= 16'd0;
      burstCount <= 16'd0;
    end else if (accept) begin
      wordCount <= wordCount + 16'd1;
      if (isLast) burstCount <= burstCount + 16'd1;
    end
  end
`endif

endmodule
